// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - request/response bundle between the execute stage and the divider
// Purpose: groups the divide request, flush and result/status signals.
// Ports (master = pipeline side, slave = divider side):
//   start, op[1:0], dividend, divisor, flush : master -> slave
//   busy, stall, done, result                : slave -> master
interface div_sequencer_if #(
   parameter int XLEN = 32
) ();
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] dividend;
   logic [XLEN-1:0] divisor;
   logic            flush;
   logic            busy;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, op, dividend, divisor, flush,
      input  busy, stall, done, result
   );

   modport slave (
      input  start, op, dividend, divisor, flush,
      output busy, stall, done, result
   );
endinterface

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - RV32M multi-cycle divide sequencer (radix-2 restoring)
// Purpose: runs DIV/DIVU/REM/REMU one quotient bit per cycle, resolves divide-by-zero and
//          signed overflow without iterating, stalls the pipeline until the result is ready.
// Ports:
//   clk    : pipeline clock
//   rst_n  : asynchronous active-low reset
//   bus    : div_sequencer_if.slave (start/op/dividend/divisor/flush in; busy/stall/done/result out)
module div_sequencer #(
   parameter int XLEN = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   div_sequencer_if.slave   bus
);

   localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

   state_t          state, state_nxt;
   logic [1:0]      op_q;
   logic            qneg_q;      // quotient must be negated (signed op, operand signs differ)
   logic            rneg_q;      // remainder must be negated (signed op, negative dividend)
   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] quo_q;       // holds the dividend magnitude, shifted out as quotient bits shift in
   logic [XLEN-1:0] dvs_q;
   logic [CW-1:0]   count_q;
   logic [XLEN-1:0] result_q;

   // Request decode on the raw inputs (only meaningful in IDLE)
   logic            in_signed, div_zero, ovf, special, accept;
   logic [XLEN-1:0] special_val, a_mag, b_mag;

   always_comb begin
      in_signed   = ~bus.op[0];
      div_zero    = (bus.divisor == '0);
      ovf         = in_signed && (bus.dividend == INT_MIN) && (bus.divisor == '1);
      special     = div_zero | ovf;
      accept      = (state == IDLE) && bus.start && !bus.flush;
      // Divide-by-zero wins over overflow (they cannot both hold anyway)
      if (div_zero)
         special_val = bus.op[1] ? bus.dividend : '1;
      else
         special_val = bus.op[1] ? '0 : INT_MIN;
      // |INT_MIN| wraps to INT_MIN, which is the correct unsigned magnitude
      a_mag = (in_signed && bus.dividend[XLEN-1]) ? (~bus.dividend + 1'b1) : bus.dividend;
      b_mag = (in_signed && bus.divisor[XLEN-1])  ? (~bus.divisor + 1'b1)  : bus.divisor;
   end

   // One restoring step; the extra bit keeps the trial difference sign-safe
   logic [XLEN:0] shifted, diff;

   always_comb begin
      shifted = {rem_q, quo_q[XLEN-1]};
      diff    = shifted - {1'b0, dvs_q};
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      if (bus.flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (bus.start) state_nxt = special ? DONE : CALC;
            CALC: if (count_q == CW'(XLEN-1)) state_nxt = SIGN;
            SIGN: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      bus.busy   = (state != IDLE);
      bus.stall  = accept || (state == CALC) || (state == SIGN);
      bus.done   = (state == DONE) && !bus.flush;
      bus.result = result_q;
   end

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         count_q  <= '0;
         result_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q    <= bus.op;
                  qneg_q  <= in_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
                  rneg_q  <= in_signed && bus.dividend[XLEN-1];
                  quo_q   <= a_mag;
                  dvs_q   <= b_mag;
                  rem_q   <= '0;
                  count_q <= '0;
                  if (special) result_q <= special_val;
               end
            end
            CALC: begin
               if (!diff[XLEN]) begin
                  rem_q <= diff[XLEN-1:0];
                  quo_q <= {quo_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_q <= shifted[XLEN-1:0];
                  quo_q <= {quo_q[XLEN-2:0], 1'b0};
               end
               count_q <= count_q + 1'b1;
            end
            SIGN: begin
               if (!bus.flush) begin
                  if (!op_q[1])
                     result_q <= qneg_q ? (~quo_q + 1'b1) : quo_q;
                  else
                     result_q <= rneg_q ? (~rem_q + 1'b1) : rem_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
